// File: rtl/dla_cdc_handshake_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : dla_cdc_handshake_responder_if
//  Description : Bundled-data request/acknowledge plus downstream valid/ready
//                signal group for the CDC handshake responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dla_cdc_handshake_responder_if #(
    parameter int WIDTH = 32
);
    logic             i_req;
    logic [WIDTH-1:0] i_data;
    logic             o_ack;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_busy;

    // Responder side: receives the request and payload, drives ack and the stream.
    modport slave (
        input  i_req,
        input  i_data,
        input  i_ready,
        output o_ack,
        output o_valid,
        output o_data,
        output o_busy
    );

    // Sender plus downstream consumer side.
    modport master (
        output i_req,
        output i_data,
        output i_ready,
        input  o_ack,
        input  o_valid,
        input  o_data,
        input  o_busy
    );
endinterface
`default_nettype wire

// File: rtl/dla_cdc_handshake_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dla_cdc_handshake_responder
//  Description : Destination-side responder of a 4-phase bundled-data crossing;
//                synchronizes req, captures the payload, returns a flopped ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module dla_cdc_handshake_responder #(
    parameter int WIDTH                = 32,
    parameter int METASTABILITY_STAGES = 3
) (
    input  wire logic                 clk,
    input  wire logic                 i_async_reset,
    dla_cdc_handshake_responder_if.slave bus
);

    // The state/ack flops act as the final resolution stage, so the request
    // path from i_req to o_ack is METASTABILITY_STAGES flops deep in total.
    localparam int c_CHAIN_LEN = METASTABILITY_STAGES - 1;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_ACK_HIGH = 1'b1
    } state_t;

    logic [c_CHAIN_LEN-1:0] r_req_chain;
    logic                   w_req_sync;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_ack;
    logic                   r_valid;
    logic [WIDTH-1:0]       r_data;
    logic                   r_busy;

    logic                   w_slot_free;
    logic                   w_capture;
    logic                   w_valid_next;

    generate
        if (c_CHAIN_LEN == 1) begin : g_chain_single
            always_ff @(posedge clk or posedge i_async_reset) begin
                if (i_async_reset) begin
                    r_req_chain <= '0;
                end else begin
                    r_req_chain <= bus.i_req;
                end
            end
        end else begin : g_chain_multi
            always_ff @(posedge clk or posedge i_async_reset) begin
                if (i_async_reset) begin
                    r_req_chain <= '0;
                end else begin
                    r_req_chain <= {r_req_chain[c_CHAIN_LEN-2:0], bus.i_req};
                end
            end
        end
    endgenerate

    // Only the final chain flop is visible to the rest of the design.
    assign w_req_sync = r_req_chain[c_CHAIN_LEN-1];

    always_comb begin
        w_slot_free  = !r_valid || bus.i_ready;
        w_capture    = (r_state == ST_IDLE) && w_req_sync && w_slot_free;
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    w_state_next = ST_ACK_HIGH;
                end
            end
            ST_ACK_HIGH: begin
                if (!w_req_sync) begin
                    w_state_next = ST_IDLE;
                end
            end
        endcase
        // A capture on the same edge as an accept refills the slot.
        if (w_capture) begin
            w_valid_next = 1'b1;
        end else if (r_valid && bus.i_ready) begin
            w_valid_next = 1'b0;
        end else begin
            w_valid_next = r_valid;
        end
    end

    always_ff @(posedge clk or posedge i_async_reset) begin
        if (i_async_reset) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= (w_state_next == ST_ACK_HIGH);
            r_valid <= w_valid_next;
            r_busy  <= (w_state_next != ST_IDLE) || w_valid_next;
            if (w_capture) begin
                r_data <= bus.i_data;
            end
        end
    end

    assign bus.o_ack   = r_ack;
    assign bus.o_valid = r_valid;
    assign bus.o_data  = r_data;
    assign bus.o_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dla_cdc_handshake_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dla_cdc_handshake_responder
//  Description : Directed and randomized self-checking bench for the responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dla_cdc_handshake_responder;

    localparam int WIDTH   = 32;
    localparam int STAGES  = 3;
    localparam int N_WORDS = 1000;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    dla_cdc_handshake_responder_if #(.WIDTH(WIDTH)) bus ();

    dla_cdc_handshake_responder #(
        .WIDTH                (WIDTH),
        .METASTABILITY_STAGES (STAGES)
    ) dut (
        .clk           (clk),
        .i_async_reset (rst),
        .bus           (bus)
    );

    // Protocol monitor, sampled just before each rising edge.
    bit               mon_en = 1'b0;
    logic             p_valid, p_ready, p_ack;
    logic             p_rst = 1'b1;
    logic [WIDTH-1:0] p_data;

    always begin
        @(negedge clk);
        #4;
        if (mon_en && !rst && !p_rst) begin
            if (p_valid === 1'b1 && p_ready === 1'b0) begin
                vectors++;
                if (bus.o_valid !== 1'b1 || bus.o_data !== p_data) begin
                    miscompares++;
                    $display("FAIL mon_hold: valid=%b data=%h, required valid=1 data=%h",
                             bus.o_valid, bus.o_data, p_data);
                end
            end
            if (p_ack === 1'b0 && bus.o_ack === 1'b1) begin
                vectors++;
                if (bus.o_valid !== 1'b1 || !(p_valid === 1'b0 || p_ready === 1'b1)) begin
                    miscompares++;
                    $display("FAIL mon_ack_rise: valid=%b prev_valid=%b prev_ready=%b, required valid=1 with free slot",
                             bus.o_valid, p_valid, p_ready);
                end
            end
        end
        p_valid = bus.o_valid;
        p_ready = bus.i_ready;
        p_ack   = bus.o_ack;
        p_data  = bus.o_data;
        p_rst   = rst;
    end

    task automatic wait_ack(input logic lvl, input int budget, output bit ok);
        int c;
        ok = 1'b0;
        c  = 0;
        while (!ok && c < budget) begin
            @(negedge clk);
            if (bus.o_ack === lvl) ok = 1'b1;
            c++;
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.o_ack, bus.o_valid, bus.o_busy} !== 3'b000 || bus.o_data !== '0) begin
            miscompares++;
            $display("FAIL reset_assert: ack/valid/busy=%b data=%h, required 000 and 0",
                     {bus.o_ack, bus.o_valid, bus.o_busy}, bus.o_data);
        end
        repeat (3) @(posedge clk);
        release_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.o_ack, bus.o_valid, bus.o_busy} !== 3'b000 || bus.o_data !== '0) begin
                miscompares++;
                $display("FAIL reset_release: ack/valid/busy=%b data=%h, required 000 and 0",
                         {bus.o_ack, bus.o_valid, bus.o_busy}, bus.o_data);
            end
        end
    endtask

    task automatic test_single_transfer();
        logic [3:0] exp;  // {ack, valid, busy, data_ok}
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_data = 32'hDEADBEEF;
        bus.i_req  = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 9) bus.i_req = 1'b0;
            if (e < 2)        exp = 4'b0000;
            else if (e == 2)  exp = 4'b1111;
            else if (e < 12)  exp = 4'b1011;
            else              exp = 4'b0001;
            if (e == 1 || e == 2 || e == 3 || e == 11 || e == 12) begin
                vectors++;
                if ({bus.o_ack, bus.o_valid, bus.o_busy} !== exp[3:1] ||
                    (exp[0] && bus.o_data !== 32'hDEADBEEF)) begin
                    miscompares++;
                    $display("FAIL single_edge%0d: ack/valid/busy=%b data=%h, required %b data_check=%b DEADBEEF",
                             e, {bus.o_ack, bus.o_valid, bus.o_busy}, bus.o_data, exp[3:1], exp[0]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        @(negedge clk);
        bus.i_ready = 1'b0;
        bus.i_data  = 32'h1;
        bus.i_req   = 1'b1;
        wait_ack(1'b1, 20, ok);
        vectors++;
        if (!ok || bus.o_data !== 32'h1 || bus.o_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_first: ack_seen=%b data=%h valid=%b, required 1 00000001 1",
                     ok, bus.o_data, bus.o_valid);
        end
        bus.i_req = 1'b0;
        wait_ack(1'b0, 20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL bp_first_release: ack=%b, required 0", bus.o_ack);
        end
        bus.i_data = 32'h2;
        bus.i_req  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.o_ack !== 1'b0 || bus.o_data !== 32'h1 || bus.o_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold cyc%0d: ack=%b data=%h valid=%b, required 0 00000001 1",
                         i, bus.o_ack, bus.o_data, bus.o_valid);
            end
        end
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1 bus.i_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.o_data !== 32'h2 || bus.o_valid !== 1'b1 || bus.o_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: data=%h valid=%b ack=%b, required 00000002 1 1",
                     bus.o_data, bus.o_valid, bus.o_ack);
        end
        bus.i_ready = 1'b1;
        bus.i_req   = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain: valid=%b, required 0", bus.o_valid);
        end
        wait_ack(1'b0, 20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL bp_final_release: ack=%b, required 0", bus.o_ack);
        end
    endtask

    task automatic test_req_held();
        bit               ok;
        int               valid_cycles;
        logic [WIDTH-1:0] word;
        word        = $urandom;
        bus.i_ready = 1'b1;
        bus.i_data  = word;
        bus.i_req   = 1'b1;
        wait_ack(1'b1, 20, ok);
        valid_cycles = (bus.o_valid === 1'b1) ? 1 : 0;
        bus.i_data   = ~word;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) valid_cycles++;
            vectors++;
            if (bus.o_ack !== 1'b1 || bus.o_data !== word) begin
                miscompares++;
                $display("FAIL held_ack cyc%0d: ack=%b data=%h, required 1 %h",
                         i, bus.o_ack, bus.o_data, word);
            end
        end
        vectors++;
        if (!ok || valid_cycles != 1) begin
            miscompares++;
            $display("FAIL held_captures: ack_seen=%b captures=%0d, required 1 1", ok, valid_cycles);
        end
        bus.i_req = 1'b0;
        wait_ack(1'b0, 20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL held_release: ack=%b, required 0", bus.o_ack);
        end
    endtask

    task automatic test_reset_mid_transfer();
        bit               ok;
        logic [WIDTH-1:0] word;
        word        = $urandom;
        bus.i_ready = 1'b0;
        bus.i_data  = word;
        bus.i_req   = 1'b1;
        wait_ack(1'b1, 20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL midrst_setup: ack=%b, required 1", bus.o_ack);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.o_ack, bus.o_valid, bus.o_busy} !== 3'b000 || bus.o_data !== '0) begin
            miscompares++;
            $display("FAIL midrst_assert: ack/valid/busy=%b data=%h, required 000 and 0",
                     {bus.o_ack, bus.o_valid, bus.o_busy}, bus.o_data);
        end
        repeat (2) @(posedge clk);
        bus.i_ready = 1'b1;
        release_reset();
        for (int e = 0; e <= 2; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e >= 1) begin
                vectors++;
                if (bus.o_ack !== (e == 2) || (e == 2 && bus.o_data !== word)) begin
                    miscompares++;
                    $display("FAIL midrst_recapture_edge%0d: ack=%b data=%h, required ack=%b data=%h",
                             e, bus.o_ack, bus.o_data, (e == 2), word);
                end
            end
        end
        bus.i_req = 1'b0;
        wait_ack(1'b0, 20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL midrst_release: ack=%b, required 0", bus.o_ack);
        end
    endtask

    task automatic test_random_stream();
        logic [WIDTH-1:0] exp_q[$];
        int               delivered = 0;
        bit               abort     = 1'b0;
        fork
            begin : sender
                bit ok;
                for (int i = 0; i < N_WORDS && !abort; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    bus.i_data = $urandom;
                    exp_q.push_back(bus.i_data);
                    bus.i_req = 1'b1;
                    wait_ack(1'b1, 500, ok);
                    if (!ok) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL rand_ack_timeout word%0d: ack=%b, required 1", i, bus.o_ack);
                        abort = 1'b1;
                    end else begin
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                        bus.i_req = 1'b0;
                        wait_ack(1'b0, 500, ok);
                        if (!ok) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL rand_release_timeout word%0d: ack=%b, required 0", i, bus.o_ack);
                            abort = 1'b1;
                        end
                    end
                end
            end
            begin : consumer
                int   cyc = 0;
                logic r;
                while (delivered < N_WORDS && !abort && cyc < 60000) begin
                    @(negedge clk);
                    cyc++;
                    r = ($urandom_range(0, 1) == 1);
                    bus.i_ready = r;
                    if (bus.o_valid === 1'b1 && r) begin
                        vectors++;
                        if (exp_q.size() == 0) begin
                            miscompares++;
                            $display("FAIL rand_duplicate: data=%h, required no word pending", bus.o_data);
                        end else begin
                            if (bus.o_data !== exp_q[0]) begin
                                miscompares++;
                                $display("FAIL rand_order word%0d: data=%h, required %h",
                                         delivered, bus.o_data, exp_q[0]);
                            end
                            void'(exp_q.pop_front());
                        end
                        delivered++;
                    end
                end
            end
        join
        @(negedge clk);
        vectors++;
        if (delivered != N_WORDS || exp_q.size() != 0 || bus.o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_totals: delivered=%0d pending=%0d valid=%b, required %0d 0 0",
                     delivered, exp_q.size(), bus.o_valid, N_WORDS);
        end
    endtask

    initial begin
        rst         = 1'b0;
        bus.i_req   = 1'b0;
        bus.i_data  = '0;
        bus.i_ready = 1'b0;
        test_reset();
        test_single_transfer();
        test_backpressure();
        test_req_held();
        test_reset_mid_transfer();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
